// File: rtl/dcache_wr_port.sv
// rtl/dcache_wr_port.sv - store-commit write port for a direct-mapped write-through data cache
//
// Accepts one committed SB/SH/SW at a time from the reorder buffer and
// serialises its bytes onto the 8-bit memory bus. Each byte also updates the
// cached line if it hits. Lines are never allocated on a store miss.
// A combinational lookup port serves loads, and a fill port lets the load
// path allocate lines.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   rdy                  global ready; 0 freezes all state
//   cache_wr_ena/addr/opt/data -> cache_wr_hit   store request / one-cycle done pulse
//   mem_req/mem_gnt      arbiter request / grant
//   mem_wr/mem_a/mem_dout  byte write strobe, byte address, byte data
//   lk_addr -> lk_hit/lk_data  load lookup (array state before the current edge)
//   fill_ena/fill_addr/fill_data  line fill from the load path
`ifndef INST_OPT_TP
`define INST_OPT_TP logic [3:0]
`endif
`ifndef OPT_SB
`define OPT_SB 4'd0
`endif
`ifndef OPT_SH
`define OPT_SH 4'd1
`endif
`ifndef OPT_SW
`define OPT_SW 4'd2
`endif

module dcache_wr_port #(
  parameter int LINE_BIT = 6,
  parameter int LINES    = 1 << LINE_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              cache_wr_ena,
  input  logic [31:0]       cache_wr_addr,
  input  `INST_OPT_TP       cache_wr_opt,
  input  logic [31:0]       cache_wr_data,
  output logic              cache_wr_hit,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_wr,
  output logic [31:0]       mem_a,
  output logic [7:0]        mem_dout,
  input  logic [31:0]       lk_addr,
  output logic              lk_hit,
  output logic [31:0]       lk_data,
  input  logic              fill_ena,
  input  logic [31:0]       fill_addr,
  input  logic [31:0]       fill_data
);
  localparam int TAG_W = 30 - LINE_BIT;

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;
  state_t state, state_next;

  logic [31:0]       st_addr;
  logic [31:0]       st_data;
  logic [2:0]        st_n;
  logic [2:0]        cnt;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  logic [2:0]          req_n;
  logic                issue;
  logic [31:0]         byte_addr;
  logic [7:0]          byte_data;
  logic [LINE_BIT-1:0] b_idx, f_idx, lk_idx;
  logic [TAG_W-1:0]    b_tag, f_tag, lk_tag;
  logic                same_idx;
  logic                byte_hit;
  logic [31:0]         lane_mask, lane_data, fill_word;
  logic                unused_addr_bits;

  // Unknown opt codes become zero-byte stores that acknowledge immediately.
  always_comb begin
    case (cache_wr_opt)
      `OPT_SB: req_n = 3'd1;
      `OPT_SH: req_n = 3'd2;
      `OPT_SW: req_n = 3'd4;
      default: req_n = 3'd0;
    endcase
  end

  assign issue     = (state == WRITE) && mem_gnt && rdy;
  assign byte_addr = st_addr + {29'd0, cnt};
  assign byte_data = st_data[{cnt[1:0], 3'b000} +: 8];

  assign b_idx  = byte_addr[LINE_BIT+1:2];
  assign b_tag  = byte_addr[31:LINE_BIT+2];
  assign f_idx  = fill_addr[LINE_BIT+1:2];
  assign f_tag  = fill_addr[31:LINE_BIT+2];
  assign lk_idx = lk_addr[LINE_BIT+1:2];
  assign lk_tag = lk_addr[31:LINE_BIT+2];
  assign unused_addr_bits = ^{lk_addr[1:0], fill_addr[1:0]};

  // A fill to the line the store byte targets lands first; the byte then
  // merges only if it belongs to the freshly filled tag.
  assign same_idx  = fill_ena && (f_idx == b_idx);
  assign byte_hit  = issue && (same_idx ? (f_tag == b_tag)
                                        : (valid[b_idx] && (tag_mem[b_idx] == b_tag)));
  assign lane_mask = 32'h0000_00FF << {byte_addr[1:0], 3'b000};
  assign lane_data = {24'd0, byte_data} << {byte_addr[1:0], 3'b000};
  assign fill_word = (byte_hit && same_idx) ? ((fill_data & ~lane_mask) | lane_data) : fill_data;

  assign mem_req  = (state == WRITE);
  assign mem_wr   = issue;
  assign mem_a    = issue ? byte_addr : 32'd0;
  assign mem_dout = issue ? byte_data : 8'd0;

  assign lk_hit  = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign lk_data = data_mem[lk_idx];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cache_wr_ena) state_next = (req_n == 3'd0) ? ACK : WRITE;
      WRITE:   if (issue && (cnt == st_n - 3'd1)) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      st_addr      <= 32'd0;
      st_data      <= 32'd0;
      st_n         <= 3'd0;
      cache_wr_hit <= 1'b0;
      valid        <= '0;
    end else if (rdy) begin
      state        <= state_next;
      // The pulse is high exactly for the cycle spent in ACK.
      cache_wr_hit <= (state_next == ACK);
      if ((state == IDLE) && cache_wr_ena) begin
        st_addr <= cache_wr_addr;
        st_data <= cache_wr_data;
        st_n    <= req_n;
        cnt     <= 3'd0;
      end
      if (issue) cnt <= cnt + 3'd1;
      if (fill_ena) valid[f_idx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (fill_ena) begin
        tag_mem[f_idx]  <= f_tag;
        data_mem[f_idx] <= fill_word;
      end
      if (byte_hit && !same_idx) data_mem[b_idx] <= (data_mem[b_idx] & ~lane_mask) | lane_data;
    end
  end
endmodule

// File: tb/tb_dcache_wr_port.sv
// tb/tb_dcache_wr_port.sv - randomized self-checking bench for dcache_wr_port
`ifndef OPT_SB
`define OPT_SB 4'd0
`endif
`ifndef OPT_SH
`define OPT_SH 4'd1
`endif
`ifndef OPT_SW
`define OPT_SW 4'd2
`endif

module tb_dcache_wr_port;
  logic        clk = 1'b0;
  logic        rst, rdy, cache_wr_ena, cache_wr_hit;
  logic [31:0] cache_wr_addr, cache_wr_data;
  logic [3:0]  cache_wr_opt;
  logic        mem_req, mem_gnt, mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic [31:0] lk_addr, lk_data;
  logic        lk_hit;
  logic        fill_ena;
  logic [31:0] fill_addr, fill_data;

  always #5 clk = ~clk;

  dcache_wr_port #(.LINE_BIT(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .cache_wr_ena(cache_wr_ena), .cache_wr_addr(cache_wr_addr),
    .cache_wr_opt(cache_wr_opt), .cache_wr_data(cache_wr_data),
    .cache_wr_hit(cache_wr_hit),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wr(mem_wr),
    .mem_a(mem_a), .mem_dout(mem_dout),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .fill_ena(fill_ena), .fill_addr(fill_addr), .fill_data(fill_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference cache: 64 one-word lines indexed by addr[7:2], tag addr[31:8].
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_word  [64];

  int          gq[$];
  int          rq[$];
  int          fill_on_byte = -1;
  logic [31:0] f_a = 32'd0;
  logic [31:0] f_d = 32'd0;
  int          last_cycles = 0;
  int          wr_pulses = 0;
  logic [23:0] tag_pool [3] = '{24'h10, 24'h20, 24'h50};

  always @(negedge clk) if (mem_wr === 1'b1) wr_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input bit fe, input logic [31:0] fa, input logic [31:0] fd,
                                     input bit be, input logic [31:0] ba, input logic [7:0] bd);
    int fi, bi, sh;
    if (fe) begin
      fi = int'(fa[7:2]);
      m_valid[fi] = 1'b1;
      m_tag[fi]   = fa[31:8];
      m_word[fi]  = fd;
    end
    if (be) begin
      bi = int'(ba[7:2]);
      sh = int'(ba[1:0]) * 8;
      if (m_valid[bi] && m_tag[bi] == ba[31:8])
        m_word[bi] = (m_word[bi] & ~(32'hFF << sh)) | ({24'd0, bd} << sh);
    end
  endfunction

  task automatic check_lk(input logic [31:0] a);
    int i;
    bit e;
    i = int'(a[7:2]);
    e = m_valid[i] && (m_tag[i] == a[31:8]);
    lk_addr = a;
    #1;
    check("lk_hit", 32'(lk_hit), 32'(e));
    if (e) check("lk_data", lk_data, m_word[i]);
  endtask

  task automatic do_fill(input logic [31:0] a, input logic [31:0] d);
    fill_ena = 1'b1; fill_addr = a; fill_data = d;
    @(posedge clk); #1;
    fill_ena = 1'b0;
    model_step(1'b1, a, d, 1'b0, 32'd0, 8'd0);
  endtask

  // gmode 0: constant grant; 1: grant/ready from gq/rq; 2: random grant/ready.
  // rst_byte >= 0 asserts reset while that byte is on the bus.
  task automatic do_store(input logic [31:0] a, input logic [3:0] opt, input logic [31:0] d,
                          input int gmode, input int rst_byte);
    int n, k, cyc;
    logic [31:0] ba, sd;
    bit g, r, fe;
    n = (opt == `OPT_SB) ? 1 : (opt == `OPT_SH) ? 2 : (opt == `OPT_SW) ? 4 : 0;
    cache_wr_ena = 1'b1; cache_wr_addr = a; cache_wr_opt = opt; cache_wr_data = d;
    rdy = 1'b1; mem_gnt = 1'b0;
    @(negedge clk);
    check("idle_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    k = 0; cyc = 0;
    while (k < n && cyc < 100) begin
      if (gmode == 0) begin
        g = 1'b1; r = 1'b1;
      end else if (gmode == 1) begin
        g = (gq.size() > 0) ? (gq.pop_front() != 0) : 1'b1;
        r = (rq.size() > 0) ? (rq.pop_front() != 0) : 1'b1;
      end else begin
        g = 1'($urandom_range(0, 1));
        r = ($urandom_range(0, 3) != 0);
      end
      fe = g && r && (k == fill_on_byte);
      mem_gnt = g; rdy = r; fill_ena = fe; fill_addr = f_a; fill_data = f_d;
      @(negedge clk);
      check("hit_early", 32'(cache_wr_hit), 32'd0);
      check("wr_req", 32'(mem_req), 32'd1);
      if (g && r) begin
        ba = a + 32'(k);
        sd = d >> (8 * k);
        check("wr_strobe", 32'(mem_wr), 32'd1);
        check("wr_addr", mem_a, ba);
        check("wr_data", 32'(mem_dout), 32'(sd[7:0]));
        if (k == rst_byte) begin
          rst = 1'b1; cache_wr_ena = 1'b0; fill_ena = 1'b0; mem_gnt = 1'b0;
          #1;
          check("rst_hit", 32'(cache_wr_hit), 32'd0);
          check("rst_req", 32'(mem_req), 32'd0);
          check("rst_wr", 32'(mem_wr), 32'd0);
          @(posedge clk); #1;
          rst = 1'b0; rdy = 1'b1;
          for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
          return;
        end
        model_step(fe, f_a, f_d, 1'b1, ba, sd[7:0]);
        k++;
      end else begin
        check("stall_wr", 32'(mem_wr), 32'd0);
        if (!g) check("stall_a", mem_a, 32'd0);
      end
      @(posedge clk); #1;
      fill_ena = 1'b0;
      cyc++;
    end
    if (k < n) check("byte_timeout", 32'(k), 32'(n));
    mem_gnt = 1'($urandom_range(0, 1)); rdy = 1'b1;
    @(negedge clk);
    check("ack_hit", 32'(cache_wr_hit), 32'd1);
    check("ack_req", 32'(mem_req), 32'd0);
    check("ack_wr", 32'(mem_wr), 32'd0);
    @(posedge clk); #1;
    cache_wr_ena = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    check("post_hit", 32'(cache_wr_hit), 32'd0);
    check("post_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    last_cycles = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, hits;
    logic [31:0] ra;
    for (int i = 0; i < 64; i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; m_word[i] = '0; end
    rst = 1'b1; rdy = 1'b1; cache_wr_ena = 1'b0; cache_wr_addr = '0; cache_wr_opt = `OPT_SB;
    cache_wr_data = '0; mem_gnt = 1'b0; lk_addr = '0; fill_ena = 1'b0; fill_addr = '0; fill_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_hit", 32'(cache_wr_hit), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_dout", 32'(mem_dout), 32'd0);
    check_lk(32'h0000_1000);

    // Full-word store over a filled line, constant grant.
    do_fill(32'h0000_1000, 32'h1122_3344);
    check_lk(32'h0000_1000);
    p0 = wr_pulses;
    do_store(32'h0000_1000, `OPT_SW, 32'hAABB_CCDD, 0, -1);
    check("sw_pulses", 32'(wr_pulses - p0), 32'd4);
    check("sw_cycles", 32'(last_cycles), 32'd4);
    lk_addr = 32'h0000_1000; #1;
    check("sw_lk_hit", 32'(lk_hit), 32'd1);
    check("sw_lk_data", lk_data, 32'hAABB_CCDD);

    // Single byte into lane 2.
    do_fill(32'h0000_1000, 32'h1122_3344);
    do_store(32'h0000_1002, `OPT_SB, 32'h0000_0055, 0, -1);
    check("sb_cycles", 32'(last_cycles), 32'd1);
    lk_addr = 32'h0000_1000; #1;
    check("sb_lk_data", lk_data, 32'h1155_3344);

    // Misaligned, line-crossing halfword to lines that miss.
    do_store(32'h0000_2003, `OPT_SH, 32'h0000_BEEF, 0, -1);
    check_lk(32'h0000_2000);
    check_lk(32'h0000_2004);
    lk_addr = 32'h0000_1000; #1;
    check("sh_other_line", lk_data, 32'h1155_3344);

    // Grant stalls and a 3-cycle rdy freeze mid-store.
    do_fill(32'h0000_3000, 32'h0BAD_F00D);
    gq = '{1, 0, 0, 1, 1, 1};
    rq = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    p0 = wr_pulses;
    do_store(32'h0000_3000, `OPT_SW, 32'h1357_9BDF, 1, -1);
    check("gnt_pulses", 32'(wr_pulses - p0), 32'd4);
    check("gnt_cycles", 32'(last_cycles), 32'd9);
    check_lk(32'h0000_3000);

    // Fill and store byte to the same line in the same cycle.
    fill_on_byte = 0; f_a = 32'h0000_1000; f_d = 32'h0000_0000;
    do_store(32'h0000_1001, `OPT_SB, 32'h0000_00FF, 0, -1);
    lk_addr = 32'h0000_1000; #1;
    check("coll_same_tag", lk_data, 32'h0000_FF00);
    f_a = 32'h0000_5000;
    do_store(32'h0000_1001, `OPT_SB, 32'h0000_00FF, 0, -1);
    fill_on_byte = -1;
    lk_addr = 32'h0000_5000; #1;
    check("coll_diff_hit", 32'(lk_hit), 32'd1);
    check("coll_diff_data", lk_data, 32'h0000_0000);
    check_lk(32'h0000_1000);

    // Reset while the second byte of a word store is on the bus.
    do_store(32'h0000_5000, `OPT_SW, 32'hCAFE_BABE, 0, 1);
    hits = 0;
    for (int i = 0; i < 64; i++) begin
      for (int t = 0; t < 3; t++) begin
        lk_addr = {tag_pool[t], 6'(i), 2'b00}; #1;
        if (lk_hit) hits++;
      end
    end
    check("rst_all_invalid", 32'(hits), 32'd0);
    p0 = wr_pulses;
    do_store(32'h0000_1000, `OPT_SB, 32'h0000_0077, 0, -1);
    check("after_rst_pulses", 32'(wr_pulses - p0), 32'd1);

    // Randomized stores, fills and collisions against the reference model.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1)
        do_fill({tag_pool[$urandom_range(0, 2)], 6'($urandom_range(0, 3)), 2'b00}, $urandom);
      fill_on_byte = int'($urandom_range(0, 4)) - 1;
      f_a = {tag_pool[$urandom_range(0, 2)], 6'($urandom_range(0, 3)), 2'b00};
      f_d = $urandom;
      ra = {tag_pool[$urandom_range(0, 2)], 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      case ($urandom_range(0, 3))
        0: do_store(ra, `OPT_SB, $urandom, 2, -1);
        1: do_store(ra, `OPT_SH, $urandom, 2, -1);
        2: do_store(ra, `OPT_SW, $urandom, 2, -1);
        default: do_store(ra, 4'd7, $urandom, 2, -1);
      endcase
      fill_on_byte = -1;
      for (int j = 0; j < 3; j++)
        check_lk({tag_pool[$urandom_range(0, 2)], 6'($urandom_range(0, 4)), 2'b00});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
